// File: rtl/env_write_arbiter_pkg.sv
// Shared types and widths for the environment write arbiter.
//   X_bits / Y_bits / SIGNAL_bits : widths of the environment write port fields
//   ENVW_REQ_num                  : default number of requesters on the write port
//   env_wr_req_t                  : one requester's write payload {x, y, signal, sugar}
//   ewa_state_t                   : arbiter FSM states
package env_write_arbiter_pkg;

  localparam int X_bits       = 8;
  localparam int Y_bits       = 7;
  localparam int SIGNAL_bits  = 8;
  localparam int ENVW_REQ_num = 4;

  typedef struct packed {
    logic [X_bits-1:0]      x;
    logic [Y_bits-1:0]      y;
    logic [SIGNAL_bits-1:0] signal;
    logic                   sugar;
  } env_wr_req_t;

  typedef enum logic [1:0] {
    EWA_IDLE     = 2'd0,
    EWA_OWN      = 2'd1,
    EWA_COOLDOWN = 2'd2
  } ewa_state_t;

endpackage

// File: rtl/env_write_arbiter_rr_picker.sv
// Combinational round-robin encoder.
//   req        : request vector
//   ptr        : index of the last requester served; scanning starts at ptr+1
//   winner     : one-hot winner (all zero when no request)
//   winner_idx : binary index of the winner
//   valid      : at least one request present
module rr_picker #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [PTR_W-1:0] winner_idx,
  output logic             valid
);

  // Walk the requesters starting just after ptr and wrapping; the first
  // asserted request wins, so the most recently served one is checked last.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand       = '0;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/env_write_arbiter.sv
// Shares the single environment write port between N_REQ requesters
// (ant-update sweep, sugar-patch placer, signal decay, host clear).
// Round-robin with a bounded hold per grant; requester 0 has strict
// priority while SETUP_MODE is high. All state on rising newLocClock.
//   newLocClock  : clock
//   RESET_SIM    : synchronous active-high reset
//   SETUP_MODE   : setup phase, requester 0 strict priority / preemption
//   req, req_*   : per-requester level request and packed write payloads
//   gnt          : registered one-hot grant
//   ack          : one-cycle pulse when the owner's write is issued (or dropped as out of range)
//   write_*      : registered write port toward the environment, write_flag is the strobe
//   busy         : arbiter not idle
//   oor_err      : one-cycle pulse when an out-of-range write was dropped
module env_write_arbiter
  import env_write_arbiter_pkg::*;
#(
  parameter int N_REQ    = ENVW_REQ_num,
  parameter int MAX_HOLD = 8,
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120
) (
  input  logic                         newLocClock,
  input  logic                         RESET_SIM,
  input  logic                         SETUP_MODE,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*X_bits-1:0]      req_x,
  input  logic [N_REQ*Y_bits-1:0]      req_y,
  input  logic [N_REQ*SIGNAL_bits-1:0] req_signal,
  input  logic [N_REQ-1:0]             req_sugar,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             ack,
  output logic [X_bits-1:0]            write_X,
  output logic [Y_bits-1:0]            write_Y,
  output logic [SIGNAL_bits-1:0]       write_signal,
  output logic                         write_sugar,
  output logic                         write_flag,
  output logic                         busy,
  output logic                         oor_err
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [X_bits-1:0] X_LAST = X_bits'(GRID_W - 1);
  localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(GRID_H - 1);
  localparam logic [N_REQ-1:0]  ONEHOT0 = N_REQ'(1);

  ewa_state_t       state, state_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [N_REQ-1:0] gnt_nxt, ack_nxt;
  logic             flag_nxt, oor_nxt;
  env_wr_req_t      wr_q, wr_nxt;

  env_wr_req_t      reqs [N_REQ];
  env_wr_req_t      cur;
  logic             in_range;
  logic             preempt;
  logic             setup_win;
  logic [N_REQ-1:0] pick_winner;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign reqs[gi] = {req_x[gi*X_bits +: X_bits],
                       req_y[gi*Y_bits +: Y_bits],
                       req_signal[gi*SIGNAL_bits +: SIGNAL_bits],
                       req_sugar[gi]};
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req        (req),
    .ptr        (rr_ptr),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign cur       = reqs[owner];
  assign in_range  = (cur.x <= X_LAST) && (cur.y <= Y_LAST);
  assign setup_win = SETUP_MODE && req[0];
  // Setup placer takes the port away from any other owner; that cycle issues no write.
  assign preempt   = SETUP_MODE && (owner != '0) && req[0];

  assign write_X      = wr_q.x;
  assign write_Y      = wr_q.y;
  assign write_signal = wr_q.signal;
  assign write_sugar  = wr_q.sugar;
  assign busy         = (state != EWA_IDLE);

  // Next-state and next-output logic. Releasing a grant always passes through
  // COOLDOWN so the environment sees a one-cycle bubble between owners.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    ack_nxt   = '0;
    flag_nxt  = 1'b0;
    oor_nxt   = 1'b0;
    wr_nxt    = wr_q;

    case (state)
      EWA_IDLE: begin
        if (pick_valid) begin
          owner_nxt = setup_win ? '0 : pick_idx;
          gnt_nxt   = setup_win ? ONEHOT0 : pick_winner;
          hold_nxt  = '0;
          state_nxt = EWA_OWN;
        end
      end

      EWA_OWN: begin
        if (preempt || !req[owner]) begin
          state_nxt = EWA_COOLDOWN;
          gnt_nxt   = '0;
          rr_nxt    = owner;
        end else begin
          ack_nxt[owner] = 1'b1;
          hold_nxt       = hold_cnt + 1'b1;
          // Out-of-range writes are dropped but still consume a hold slot.
          if (in_range) begin
            flag_nxt = 1'b1;
            wr_nxt   = cur;
          end else begin
            oor_nxt  = 1'b1;
          end
          if (hold_nxt == HOLD_W'(MAX_HOLD)) begin
            state_nxt = EWA_COOLDOWN;
            gnt_nxt   = '0;
            rr_nxt    = owner;
          end
        end
      end

      EWA_COOLDOWN: state_nxt = EWA_IDLE;

      default: begin
        state_nxt = EWA_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything and aims the
  // round-robin pointer so requester 0 wins the first arbitration.
  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      state      <= EWA_IDLE;
      owner      <= '0;
      rr_ptr     <= PTR_W'(N_REQ - 1);
      hold_cnt   <= '0;
      gnt        <= '0;
      ack        <= '0;
      write_flag <= 1'b0;
      oor_err    <= 1'b0;
      wr_q       <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_nxt;
      hold_cnt   <= hold_nxt;
      gnt        <= gnt_nxt;
      ack        <= ack_nxt;
      write_flag <= flag_nxt;
      oor_err    <= oor_nxt;
      wr_q       <= wr_nxt;
    end
  end

endmodule
